// File: rtl/list_scan.sv
// Indexed list of up to LENGTH entries: read/insert/delete/append/clear in one cycle,
// plus FIND and SUM scans that walk one entry per clock while op_in_progress is high.
module list_scan #(
  parameter int DATA_WIDTH   = 8,
  parameter int LENGTH       = 8,
  parameter int LENGTH_WIDTH = $clog2(LENGTH + 1)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [2:0]                       op_sel,
  input  logic                             op_en,
  input  logic [DATA_WIDTH-1:0]            data_in,
  input  logic [LENGTH_WIDTH-1:0]          index_in,
  output logic [LENGTH_WIDTH+DATA_WIDTH-1:0] data_out,
  output logic                             op_done,
  output logic                             op_in_progress,
  output logic                             op_error,
  output logic [LENGTH_WIDTH-1:0]          len
);

  localparam int LW = LENGTH_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int OW = LW + DW;
  localparam logic [LW-1:0] FULL = LW'(LENGTH);

  localparam logic [2:0] OP_READ   = 3'd0;
  localparam logic [2:0] OP_INSERT = 3'd1;
  localparam logic [2:0] OP_DELETE = 3'd2;
  localparam logic [2:0] OP_PUSH   = 3'd3;
  localparam logic [2:0] OP_FIND   = 3'd4;
  localparam logic [2:0] OP_SUM    = 3'd5;
  localparam logic [2:0] OP_CLEAR  = 3'd6;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t          state_q, state_d;
  logic            sum_mode_q, sum_mode_d;
  logic [LW-1:0]   ptr_q, ptr_d;
  logic [OW-1:0]   acc_q, acc_d;
  logic [DW-1:0]   key_q, key_d;
  logic [DW-1:0]   entries_q [LENGTH];
  logic [DW-1:0]   entries_d [LENGTH];
  logic [LW-1:0]   len_q, len_d;
  logic [OW-1:0]   dout_q, dout_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic [DW-1:0]   idx_ent;
  logic [DW-1:0]   ptr_ent;
  logic            scan_last;
  logic [OW-1:0]   acc_sum;

  // Decoded muxes avoid indexing the array with the wider length-sized fields.
  always_comb begin
    idx_ent = '0;
    ptr_ent = '0;
    for (int i = 0; i < LENGTH; i++) begin
      if (index_in == LW'(i)) idx_ent = entries_q[i];
      if (ptr_q == LW'(i))    ptr_ent = entries_q[i];
    end
  end

  assign scan_last = (ptr_q == len_q - LW'(1));
  assign acc_sum   = acc_q + OW'(ptr_ent);

  always_comb begin
    state_d    = state_q;
    sum_mode_d = sum_mode_q;
    ptr_d      = ptr_q;
    acc_d      = acc_q;
    key_d      = key_q;
    entries_d  = entries_q;
    len_d      = len_q;
    dout_d     = dout_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (op_en) begin
          case (op_sel)
            OP_READ: begin
              done_d = 1'b1;
              if (index_in >= len_q) err_d = 1'b1;
              else dout_d = {index_in, idx_ent};
            end
            OP_INSERT: begin
              done_d = 1'b1;
              if (len_q == FULL || index_in > len_q) begin
                err_d = 1'b1;
              end else begin
                for (int i = 1; i < LENGTH; i++)
                  if (LW'(i) > index_in && LW'(i) <= len_q) entries_d[i] = entries_q[i-1];
                for (int i = 0; i < LENGTH; i++)
                  if (LW'(i) == index_in) entries_d[i] = data_in;
                len_d  = len_q + LW'(1);
                dout_d = {len_q + LW'(1), data_in};
              end
            end
            OP_DELETE: begin
              done_d = 1'b1;
              if (index_in >= len_q) begin
                err_d = 1'b1;
              end else begin
                for (int i = 0; i < LENGTH - 1; i++)
                  if (LW'(i) >= index_in) entries_d[i] = entries_q[i+1];
                len_d  = len_q - LW'(1);
                dout_d = {len_q - LW'(1), idx_ent};
              end
            end
            OP_PUSH: begin
              done_d = 1'b1;
              if (len_q == FULL) begin
                err_d = 1'b1;
              end else begin
                for (int i = 0; i < LENGTH; i++)
                  if (LW'(i) == len_q) entries_d[i] = data_in;
                len_d  = len_q + LW'(1);
                dout_d = {len_q + LW'(1), data_in};
              end
            end
            OP_FIND: begin
              if (len_q == '0) begin
                done_d = 1'b1;
                err_d  = 1'b1;
              end else begin
                state_d    = SCAN;
                sum_mode_d = 1'b0;
                ptr_d      = '0;
                key_d      = data_in;
              end
            end
            OP_SUM: begin
              if (len_q == '0) begin
                done_d = 1'b1;
                dout_d = '0;
              end else begin
                state_d    = SCAN;
                sum_mode_d = 1'b1;
                ptr_d      = '0;
                acc_d      = '0;
              end
            end
            OP_CLEAR: begin
              done_d = 1'b1;
              len_d  = '0;
              dout_d = '0;
            end
            default: begin
              done_d = 1'b1;
              err_d  = 1'b1;
            end
          endcase
        end
      end
      SCAN: begin
        if (sum_mode_q) begin
          acc_d = acc_sum;
          if (scan_last) begin
            state_d = IDLE;
            done_d  = 1'b1;
            dout_d  = acc_sum;
          end else begin
            ptr_d = ptr_q + LW'(1);
          end
        end else if (ptr_ent == key_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
          dout_d  = {ptr_q, ptr_ent};
        end else if (scan_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          ptr_d = ptr_q + LW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sum_mode_q <= 1'b0;
      ptr_q      <= '0;
      acc_q      <= '0;
      key_q      <= '0;
      entries_q  <= '{default: '0};
      len_q      <= '0;
      dout_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sum_mode_q <= sum_mode_d;
      ptr_q      <= ptr_d;
      acc_q      <= acc_d;
      key_q      <= key_d;
      entries_q  <= entries_d;
      len_q      <= len_d;
      dout_q     <= dout_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign data_out       = dout_q;
  assign op_done        = done_q;
  assign op_error       = err_q;
  assign op_in_progress = (state_q == SCAN);
  assign len            = len_q;

endmodule

// File: tb/tb_list_scan.sv
// Bench for list_scan: directed scenarios plus random commands checked against a queue model.
module tb_list_scan;
  localparam int DW = 8;
  localparam int L  = 8;
  localparam int LW = $clog2(L + 1);
  localparam int OW = LW + DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [2:0]    op_sel = '0;
  logic          op_en = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [LW-1:0] index_in = '0;
  logic [OW-1:0] data_out;
  logic          op_done, op_in_progress, op_error;
  logic [LW-1:0] len;

  list_scan #(.DATA_WIDTH(DW), .LENGTH(L)) dut (
    .clk(clk), .rst_n(rst_n), .op_sel(op_sel), .op_en(op_en),
    .data_in(data_in), .index_in(index_in), .data_out(data_out),
    .op_done(op_done), .op_in_progress(op_in_progress),
    .op_error(op_error), .len(len)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] q[$];
  logic [OW-1:0] exp_dout = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Issues one command, follows it to completion, and compares against the queue model.
  task automatic run_cmd(input logic [2:0] op, input logic [DW-1:0] d,
                         input logic [LW-1:0] idx, input bit junk);
    int n_exp, sz, k, n, busy;
    bit err;
    logic [OW-1:0] s;
    sz = q.size();
    n_exp = 1;
    err = 1'b0;
    case (op)
      3'd0: if (int'(idx) >= sz) err = 1'b1; else exp_dout = {idx, q[idx]};
      3'd1: if (sz == L || int'(idx) > sz) err = 1'b1;
            else begin q.insert(int'(idx), d); exp_dout = {LW'(sz + 1), d}; end
      3'd2: if (int'(idx) >= sz) err = 1'b1;
            else begin exp_dout = {LW'(sz - 1), q[idx]}; q.delete(int'(idx)); end
      3'd3: if (sz == L) err = 1'b1;
            else begin q.push_back(d); exp_dout = {LW'(sz + 1), d}; end
      3'd4: begin
        if (sz == 0) err = 1'b1;
        else begin
          k = -1;
          foreach (q[i]) if (k < 0 && q[i] == d) k = i;
          if (k >= 0) begin n_exp = k + 2; exp_dout = {LW'(k), d}; end
          else begin n_exp = sz + 1; err = 1'b1; end
        end
      end
      3'd5: begin
        if (sz == 0) exp_dout = '0;
        else begin
          s = '0;
          foreach (q[i]) s += OW'(q[i]);
          n_exp = sz + 1;
          exp_dout = s;
        end
      end
      3'd6: begin q.delete(); exp_dout = '0; end
      default: err = 1'b1;
    endcase

    op_sel = op; data_in = d; index_in = idx; op_en = 1'b1;
    @(posedge clk); #1;
    op_en = 1'b0;
    n = 1;
    busy = 0;
    while (!op_done && n < L + 4) begin
      busy += int'(op_in_progress);
      if (junk) begin
        op_en = 1'b1; op_sel = 3'd3; data_in = DW'($urandom);
      end
      @(posedge clk); #1;
      op_en = 1'b0;
      n++;
    end
    check("done_latency", n, n_exp);
    check("busy_cycles", busy, n_exp - 1);
    check("busy_at_done", op_in_progress, 0);
    check("op_error", op_error, err);
    check("len", len, q.size());
    check("data_out", data_out, exp_dout);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_data_out", data_out, 0);
    check("rst_op_done", op_done, 0);
    check("rst_busy", op_in_progress, 0);
    check("rst_op_error", op_error, 0);
    check("rst_len", len, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_cmd(3'd3, 8'h11, 0, 0);
    run_cmd(3'd3, 8'h22, 0, 0);
    run_cmd(3'd3, 8'h33, 0, 0);
    check("len_after_push3", len, 3);
    run_cmd(3'd0, 8'h00, 1, 0);
    check("read_idx1", data_out, 12'h122);

    run_cmd(3'd1, 8'h44, 0, 0);
    check("insert_front", data_out, 12'h444);
    for (int i = 0; i < 4; i++) run_cmd(3'd0, 8'h00, LW'(i), 0);
    check("read_idx3", data_out, 12'h333);
    run_cmd(3'd2, 8'h00, 2, 0);
    check("delete_idx2", data_out, 12'h322);

    run_cmd(3'd4, 8'h33, 0, 0);
    check("find_hit", data_out, 12'h233);
    run_cmd(3'd4, 8'h99, 0, 1);
    check("find_miss_hold", data_out, 12'h233);

    run_cmd(3'd6, 8'h00, 0, 0);
    for (int i = 0; i < L; i++) run_cmd(3'd3, 8'hFF, 0, 0);
    run_cmd(3'd5, 8'h00, 0, 1);
    check("sum_full_ff", data_out, 12'h7F8);
    check("len_after_sum", len, 8);

    run_cmd(3'd3, 8'h55, 0, 0);
    run_cmd(3'd1, 8'h55, 3, 0);
    run_cmd(3'd0, 8'h00, 8, 0);
    run_cmd(3'd6, 8'h00, 0, 0);
    run_cmd(3'd2, 8'h00, 0, 0);
    run_cmd(3'd7, 8'h00, 0, 0);
    run_cmd(3'd4, 8'h00, 0, 0);
    run_cmd(3'd5, 8'h00, 0, 0);
    check("sum_empty", data_out, 0);

    for (int i = 0; i < L; i++) run_cmd(3'd3, 8'hFF, 0, 0);
    op_sel = 3'd5; op_en = 1'b1;
    @(posedge clk); #1;
    op_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset_data_out", data_out, 0);
    check("midreset_busy", op_in_progress, 0);
    check("midreset_len", len, 0);
    @(posedge clk); #1;
    check("midreset_no_done", op_done, 0);
    rst_n = 1'b1;
    q.delete();
    exp_dout = '0;
    run_cmd(3'd0, 8'h00, 0, 0);

    for (int i = 0; i < 300; i++) begin
      logic [2:0] op;
      logic [DW-1:0] d;
      op = 3'($urandom_range(0, 7));
      if (op == 3'd6 && $urandom_range(0, 3) != 0) op = 3'd3;
      d = ($urandom_range(0, 1) == 1) ? DW'($urandom_range(0, 3)) : DW'($urandom);
      run_cmd(op, d, LW'($urandom_range(0, L + 1)), bit'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
